bcd_serial_addsub: RTL and testbench

Parametrised multi-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first, with a start/busy/done handshake. It builds on the single-digit combinational BCD adder for wide decimal operands, where a flat ripple of digit adders would be too long a path. It adds subtraction (nine's-complement), digit-validity checking, and registered, held results for the arithmetic datapath of the lab processor.

---
 rtl/bcd_serial_addsub.sv | 89 ++++++++
 tb/tb_bcd_serial_addsub.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial multi-digit BCD adder/subtractor with start/busy/done handshake
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic [4*DIGITS-1:0] s,
  output logic                cout,
  output logic                invalid,
  output logic                busy,
  output logic                done
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state;
  logic [W-1:0]    a_sh, b_sh, res, b_nc;
  logic [DIGITS-1:0] bad;
  logic [IW-1:0]   idx;
  logic            c, inv;
  logic [4:0]      t;
  logic [3:0]      dig;
  logic [W+3:0]    res_nx;
  // per-digit nine's complement of b and digit-validity flags of the incoming operands
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign b_nc[4*i+:4] = 4'd9 - b[4*i+:4];
    assign bad[i]       = (a[4*i+:4] > 4'd9) | (b[4*i+:4] > 4'd9);
  end
  // one-digit BCD add on the current low digits; the new digit enters the result from the top
  always_comb begin
    t      = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, c};
    dig    = (t > 5'd9) ? t[3:0] + 4'd6 : t[3:0];
    res_nx = {dig, res};
  end
  // control FSM and digit-serial datapath; s/cout/invalid only move on the completing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      idx     <= '0;
      c       <= 1'b0;
      inv     <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= start ? RUN : IDLE;
          if (start) begin
            a_sh <= a;
            b_sh <= sub ? b_nc : b;
            c    <= sub ? ~cin : cin;
            inv  <= |bad;
            res  <= '0;
            idx  <= '0;
            busy <= 1'b1;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          c    <= t > 5'd9;
          res  <= res_nx[W+3:4];
          idx  <= idx + IW'(1);
          if (idx == IW'(DIGITS - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            s       <= res_nx[W+3:4];
            cout    <= t > 5'd9;
            invalid <= inv;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb_bcd_serial_addsub: randomized and directed checks against a decimal-arithmetic reference
module tb_bcd_serial_addsub;
  localparam int D = 4;
  logic clk = 0, rst = 1, start = 0, sub = 0, cin = 0;
  logic [4*D-1:0] a = '0, b = '0, s;
  logic cout, invalid, busy, done;
  int vectors = 0, miscompares = 0;

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s), .cout(cout), .invalid(invalid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [4*D-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
    return r;
  endfunction

  function automatic logic [4*D-1:0] int2bcd(input int v);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // expected {invalid, cout, s}
  function automatic logic [4*D+1:0] model(input logic [4*D-1:0] av, bv, input logic sv, cv);
    logic bad = 0;
    int lim = 1, x, c;
    logic [4*D-1:0] r = '0;
    logic [3:0] bd;
    for (int i = 0; i < D; i++) begin
      bad |= (av[4*i+:4] > 9) || (bv[4*i+:4] > 9);
      lim *= 10;
    end
    if (!bad) begin
      if (!sv) begin
        x = bcd2int(av) + bcd2int(bv) + int'(cv);
        return {1'b0, x >= lim, int2bcd(x % lim)};
      end
      x = bcd2int(av) - bcd2int(bv) - int'(cv);
      return {1'b0, x >= 0, int2bcd(x < 0 ? x + lim : x)};
    end
    c = sv ? int'(!cv) : int'(cv);
    for (int i = 0; i < D; i++) begin
      bd = sv ? 4'd9 - bv[4*i+:4] : bv[4*i+:4];
      x = int'(av[4*i+:4]) + int'(bd) + c;
      c = x > 9 ? 1 : 0;
      r[4*i+:4] = 4'(x > 9 ? x + 6 : x);
    end
    return {1'b1, c == 1, r};
  endfunction

  task automatic wait_done(input string tag, input logic [4*D-1:0] av, bv, input logic sv, cv, input int n0);
    logic [4*D+1:0] e = model(av, bv, sv, cv);
    int n = n0, bc = n0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, D);
    chk({tag, " busy cycles"}, bc, D);
    chk({tag, " busy at done"}, busy, 0);
    chk({tag, " s"}, s, e[4*D-1:0]);
    chk({tag, " cout"}, cout, e[4*D]);
    chk({tag, " invalid"}, invalid, e[4*D+1]);
  endtask

  task automatic launch(input logic [4*D-1:0] av, bv, input logic sv, cv);
    start = 1; a = av; b = bv; sub = sv; cin = cv;
    @(posedge clk); #1;
    start = 0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
  endtask

  task automatic op(input string tag, input logic [4*D-1:0] av, bv, input logic sv, cv);
    logic [4*D-1:0] hs;
    launch(av, bv, sv, cv);
    wait_done(tag, av, bv, sv, cv, 0);
    hs = s;
    @(posedge clk); #1;
    chk({tag, " done single"}, done, 0);
    chk({tag, " s held"}, s, hs);
  endtask

  function automatic logic [4*D-1:0] rnd_op(input bit allow_bad);
    logic [4*D-1:0] r;
    for (int i = 0; i < D; i++) r[4*i+:4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 7) == 0) r[4*$urandom_range(0, D-1)+:4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  initial begin
    logic [4*D-1:0] ra, rb;
    logic rs, rc;
    int dn;
    repeat (2) @(posedge clk);
    #1;
    chk("reset s", s, 0);
    chk("reset cout", cout, 0);
    chk("reset invalid", invalid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst = 0;
    @(posedge clk); #1;
    op("add 999+1", 16'h0999, 16'h0001, 0, 0);
    op("add 9999+1", 16'h9999, 16'h0001, 0, 0);
    op("add cin", 16'h4567, 16'h5432, 0, 1);
    op("sub pos", 16'h0500, 16'h0123, 1, 0);
    op("sub neg", 16'h0123, 16'h0500, 1, 0);
    op("sub borrow", 16'h0000, 16'h0000, 1, 1);
    op("add bad", 16'h000A, 16'h0000, 0, 0);
    // invalid must hold through the next run and clear only at its done
    launch(16'h1234, 16'h1111, 0, 0);
    chk("invalid held in run", invalid, 1);
    wait_done("valid after bad", 16'h1234, 16'h1111, 0, 0, 0);
    @(posedge clk); #1;
    // start during RUN is ignored
    launch(16'h2468, 16'h1357, 0, 0);
    @(posedge clk); #1;
    start = 1; a = 16'h9999; b = 16'h9999;
    @(posedge clk); #1;
    start = 0;
    wait_done("ignore start", 16'h2468, 16'h1357, 0, 0, 2);
    // back-to-back: start in the DONE cycle
    launch(16'h0042, 16'h0058, 0, 0);
    wait_done("b2b first", 16'h0042, 16'h0058, 0, 0, 0);
    launch(16'h8000, 16'h0001, 1, 0);
    wait_done("b2b second", 16'h8000, 16'h0001, 1, 0, 0);
    @(posedge clk); #1;
    // reset mid-run
    launch(16'h0999, 16'h0001, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst s", s, 0);
    chk("midrst cout", cout, 0);
    chk("midrst invalid", invalid, 0);
    @(posedge clk); #1;
    rst = 0;
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      dn += int'(done) + int'(busy);
    end
    chk("midrst no done", dn, 0);
    op("after rst", 16'h5000, 16'h4999, 1, 1);
    // randomized
    for (int k = 0; k < 40; k++) begin
      ra = rnd_op(1); rb = rnd_op(1);
      rs = 1'($urandom); rc = 1'($urandom);
      op("rand", ra, rb, rs, rc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
